// File: rtl/signext_pkg.sv
// -----------------------------------------------------------------------------
// signext_pkg
//   Shared definitions for the immediate-extension block.
//   - ext_op_e : extension mode encoding driven on the 2-bit ext_op port
//   - SIGNEXT_IN_W / SIGNEXT_OUT_W : default immediate and result widths
//   - BRANCH_SHIFT : left shift applied in branch-offset mode
// -----------------------------------------------------------------------------
package signext_pkg;

    // Default widths: 16-bit immediate field extended to a 32-bit word.
    localparam int SIGNEXT_IN_W  = 16;
    localparam int SIGNEXT_OUT_W = 32;

    // Branch offsets are word offsets, so the sign-extended value is scaled
    // by 4 to produce a byte offset.
    localparam int BRANCH_SHIFT = 2;

    // Extension mode encoding.
    typedef enum logic [1:0] {
        EXT_SIGN   = 2'b00,  // replicate the sign bit into the upper bits
        EXT_ZERO   = 2'b01,  // fill the upper bits with zeros
        EXT_UPPER  = 2'b10,  // place immediate in the top bits (load-upper)
        EXT_BRANCH = 2'b11   // sign-extend, then scale by 4
    } ext_op_e;

endpackage : signext_pkg

// File: rtl/signext_core.sv
// -----------------------------------------------------------------------------
// signext_core
//   Purely combinational immediate extender. Produces the OUT_W-bit extended
//   value of an IN_W-bit immediate according to the selected mode.
//
//   Parameters
//     IN_W   : immediate width (bit IN_W-1 is the sign bit)
//     OUT_W  : result width, expected to be at least 2*IN_W
//
//   Ports
//     inst   : in  [IN_W-1:0]  immediate field
//     ext_op : in  [1:0]       extension mode (see signext_pkg::ext_op_e)
//     ext    : out [OUT_W-1:0] extended result
// -----------------------------------------------------------------------------
module signext_core
    import signext_pkg::*;
#(
    parameter int IN_W  = SIGNEXT_IN_W,
    parameter int OUT_W = SIGNEXT_OUT_W
) (
    input  logic [IN_W-1:0]  inst,
    input  logic [1:0]       ext_op,
    output logic [OUT_W-1:0] ext
);

    logic signed [IN_W-1:0]  inst_s;
    logic signed [OUT_W-1:0] sext_s;
    logic        [OUT_W-1:0] zext;
    logic        [OUT_W-1:0] upper;
    logic        [OUT_W-1:0] branch;

    // Signed view of the immediate so the sign extension reads as arithmetic
    // widening rather than manual bit replication.
    assign inst_s = signed'(inst);
    assign sext_s = OUT_W'(inst_s);

    assign zext   = {{(OUT_W-IN_W){1'b0}}, inst};
    assign upper  = {inst, {(OUT_W-IN_W){1'b0}}};

    // Bits shifted out of the top are discarded; the low bits become zero.
    assign branch = unsigned'(sext_s) << BRANCH_SHIFT;

    always_comb begin
        ext = '0;
        case (ext_op_e'(ext_op))
            EXT_SIGN:   ext = unsigned'(sext_s);
            EXT_ZERO:   ext = zext;
            EXT_UPPER:  ext = upper;
            EXT_BRANCH: ext = branch;
            default:    ext = '0;
        endcase
    end

endmodule : signext_core

// File: rtl/signext.sv
// -----------------------------------------------------------------------------
// signext
//   Registered immediate extender. The combinational extender result is
//   captured on each rising clock edge where in_valid is high; the output is
//   driven only from registers, giving a fixed one-cycle latency with full
//   throughput (one result per cycle, no backpressure).
//
//   Parameters
//     IN_W      : immediate width (default 16)
//     OUT_W     : result width (default 32), must be >= 2*IN_W
//
//   Ports
//     clk       : in  rising-edge clock
//     rst_n     : in  asynchronous active-low reset
//     inst      : in  [IN_W-1:0]  immediate field
//     ext_op    : in  [1:0]       extension mode
//     in_valid  : in  qualifies inst/ext_op for capture
//     data      : out [OUT_W-1:0] registered extended result (held when idle)
//     out_valid : out high for the cycle following a valid capture
// -----------------------------------------------------------------------------
module signext
    import signext_pkg::*;
#(
    parameter int IN_W  = SIGNEXT_IN_W,
    parameter int OUT_W = SIGNEXT_OUT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IN_W-1:0]  inst,
    input  logic [1:0]       ext_op,
    input  logic             in_valid,
    output logic [OUT_W-1:0] data,
    output logic             out_valid
);

    // Upper mode places the whole immediate above an IN_W-wide zero field,
    // so a narrower result cannot represent it.
    if (OUT_W < 2*IN_W) begin : g_width_check
        $error("signext: OUT_W must be at least 2*IN_W");
    end

    logic [OUT_W-1:0] ext_p0;
    logic             vld_p0;
    logic [OUT_W-1:0] data_p1;
    logic             vld_p1;

    // ---- Stage 0: combinational extension of the incoming immediate ----
    signext_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .inst   (inst),
        .ext_op (ext_op),
        .ext    (ext_p0)
    );

    assign vld_p0 = in_valid;

    // ---- Stage 1: output register ----
    // The data register is cleared by reset too, so a result pending at reset
    // time is discarded and the output reads zero while reset is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_p1 <= '0;
            vld_p1  <= 1'b0;
        end else begin
            vld_p1 <= vld_p0;
            if (vld_p0) begin
                data_p1 <= ext_p0;
            end
        end
    end

    assign data      = data_p1;
    assign out_valid = vld_p1;

endmodule : signext

// File: tb/tb_signext.sv
// -----------------------------------------------------------------------------
// tb_signext
//   Self-checking bench for signext with default widths (16 -> 32).
// -----------------------------------------------------------------------------
module tb_signext;

    logic        clk;
    logic        rst_n;
    logic [15:0] inst;
    logic [1:0]  ext_op;
    logic        in_valid;
    logic [31:0] data;
    logic        out_valid;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_data;
    logic        exp_vld;

    signext #(
        .IN_W  (16),
        .OUT_W (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .inst      (inst),
        .ext_op    (ext_op),
        .in_valid  (in_valid),
        .data      (data),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, required completion");
        $fatal(1, "watchdog");
    end

    // Reference: the immediate is interpreted as an integer and the result
    // is that integer's value reduced modulo 2^32.
    function automatic logic [31:0] ref_ext(input logic [15:0] i, input logic [1:0] op);
        longint u;
        longint s;
        longint r;
        u = longint'(i);
        s = (u >= 32768) ? (u - 65536) : u;
        case (op)
            2'd0:    r = s;
            2'd1:    r = u;
            2'd2:    r = u * 65536;
            default: r = s * 4;
        endcase
        return r[31:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".data"}, data, exp_data);
        check({tag, ".valid"}, {31'b0, out_valid}, {31'b0, exp_vld});
    endtask

    // Drive one cycle of input, advance past the edge, update the model and
    // compare the registered outputs.
    task automatic step(input logic [15:0] i, input logic [1:0] op, input logic v, input string tag);
        inst     = i;
        ext_op   = op;
        in_valid = v;
        @(posedge clk);
        #1;
        if (v) exp_data = ref_ext(i, op);
        exp_vld = v;
        check_outputs(tag);
    endtask

    task automatic check_const(input string tag, input logic [31:0] expv);
        check(tag, data, expv);
    endtask

    initial begin
        rst_n    = 1'b1;
        inst     = 16'h5A5A;
        ext_op   = 2'b11;
        in_valid = 1'b1;
        exp_data = '0;
        exp_vld  = 1'b0;

        // Asynchronous reset before any clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs("reset_async");
        @(posedge clk);
        #1;
        check_outputs("reset_held_clk");
        rst_n    = 1'b1;
        in_valid = 1'b0;
        step(16'h1234, 2'd0, 1'b0, "release_no_valid");

        // Directed vectors with fixed required results.
        step(16'h23AD, 2'd0, 1'b1, "pos_sign");
        check_const("pos_sign_const", 32'h000023AD);
        step(16'hA3AD, 2'd0, 1'b1, "neg_sign");
        check_const("neg_sign_const", 32'hFFFFA3AD);
        step(16'hA3AD, 2'd1, 1'b1, "zero_ext");
        check_const("zero_ext_const", 32'h0000A3AD);
        step(16'hA3AD, 2'd2, 1'b1, "upper");
        check_const("upper_const", 32'hA3AD0000);
        step(16'hFFFF, 2'd3, 1'b1, "branch_ffff");
        check_const("branch_ffff_const", 32'hFFFFFFFC);
        step(16'h7FFF, 2'd0, 1'b1, "bound_7fff");
        check_const("bound_7fff_const", 32'h00007FFF);
        step(16'h8000, 2'd0, 1'b1, "bound_8000");
        check_const("bound_8000_const", 32'hFFFF8000);
        step(16'h7FFF, 2'd3, 1'b1, "branch_7fff");
        check_const("branch_7fff_const", 32'h0001FFFC);

        // Zero immediate yields zero in every mode.
        for (int m = 0; m < 4; m++) begin
            step(16'h0000, 2'(m), 1'b1, "zero_inst");
            check_const("zero_inst_const", 32'h0);
        end

        // Streaming then hold.
        step(16'h0001, 2'd0, 1'b1, "stream_a");
        check_const("stream_a_const", 32'h00000001);
        step(16'h8000, 2'd0, 1'b1, "stream_b");
        check_const("stream_b_const", 32'hFFFF8000);
        step(16'h1111, 2'd1, 1'b0, "hold_1");
        check_const("hold_1_const", 32'hFFFF8000);
        step(16'h2222, 2'd2, 1'b0, "hold_2");
        check_const("hold_2_const", 32'hFFFF8000);

        // Mid-stream reset: clears without an edge, stays clear through edges.
        step(16'h4321, 2'd2, 1'b1, "pre_reset");
        inst     = 16'hBEEF;
        ext_op   = 2'd0;
        in_valid = 1'b1;
        rst_n    = 1'b0;
        exp_data = '0;
        exp_vld  = 1'b0;
        #1;
        check_outputs("midreset_async");
        @(posedge clk);
        #1;
        check_outputs("midreset_held");
        rst_n    = 1'b1;
        in_valid = 1'b0;
        step(16'hBEEF, 2'd0, 1'b0, "midreset_release");
        step(16'hBEEF, 2'd0, 1'b1, "post_reset");
        check_const("post_reset_const", 32'hFFFFBEEF);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 300; n++) begin
            step(16'($urandom), 2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0), "random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_signext
